// File: rtl/reference_index_sequencer.sv
// ---------------------------------------------------------------------------
// reference_index_sequencer
//
// Generates the buffer indices for a lagged sweep over a circular reference
// buffer. A run covers lag_count lags. For each lag it streams sweep_length
// indices (lag + k) mod buffer_length, for k = 0 .. sweep_length-1, on an
// AXI-Stream style master. A one-cycle gap separates consecutive sweeps.
//
// Parameters
//   buffer_bits    width of the buffer index and of the lag output
//   buffer_length  number of valid buffer entries (2 .. 2**buffer_bits)
//   sweep_length   beats per lag sweep (1 .. buffer_length)
//   lag_count      lags per run (1 .. buffer_length)
//
// Ports
//   clk                  single clock, rising edge
//   reset                synchronous, active-high reset
//   start                run request, only looked at while idle
//   busy                 high whenever a run is in progress (not idle)
//   done                 one-cycle pulse when a run completes
//   m_axis_index_tdata   buffer index of the current beat
//   m_axis_index_tvalid  index valid
//   m_axis_index_tready  downstream accepts the index
//   m_axis_index_tlast   final beat of the current sweep
//   lag                  lag of the current (or most recent) sweep
// ---------------------------------------------------------------------------
module reference_index_sequencer #(
    parameter int buffer_bits   = 10,
    parameter int buffer_length = 1024,
    parameter int sweep_length  = 256,
    parameter int lag_count     = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    output logic                   busy,
    output logic                   done,
    output logic [buffer_bits-1:0] m_axis_index_tdata,
    output logic                   m_axis_index_tvalid,
    input  logic                   m_axis_index_tready,
    output logic                   m_axis_index_tlast,
    output logic [buffer_bits-1:0] lag
);

    typedef enum logic [1:0] {
        IDLE,
        SWEEP,
        NEXT_LAG,
        DONE
    } state_t;

    // One extra bit so lag + k (both < buffer_length) never overflows, and
    // so buffer_length == 2**buffer_bits is still representable.
    localparam int ext_bits = buffer_bits + 1;

    localparam logic [ext_bits-1:0] length_ext   = ext_bits'(buffer_length);
    localparam logic [ext_bits-1:0] sweep_last   = ext_bits'(sweep_length - 1);
    localparam logic [ext_bits-1:0] lag_last     = ext_bits'(lag_count - 1);
    // A one-beat sweep raises tlast on its very first beat.
    localparam logic                first_is_last = (sweep_length == 1);

    // ------------------------------------------------------------------
    // State and registered outputs
    // ------------------------------------------------------------------
    state_t                 state_reg;
    logic [buffer_bits-1:0] lag_reg;
    logic [buffer_bits-1:0] k_reg;
    logic [buffer_bits-1:0] tdata_reg;
    logic                   tvalid_reg;
    logic                   tlast_reg;
    logic                   busy_reg;
    logic                   done_reg;

    // ------------------------------------------------------------------
    // Next-index datapath
    // ------------------------------------------------------------------
    logic [buffer_bits-1:0] k_next;
    logic [buffer_bits-1:0] lag_next;
    logic [ext_bits-1:0]    add_a;
    logic [ext_bits-1:0]    add_b;
    logic [ext_bits-1:0]    sum_ext;
    logic [ext_bits-1:0]    wrap_ext;
    logic [buffer_bits-1:0] index_next;
    logic                   beat_xfer;
    logic                   unused_wrap_msb;

    // Only used while k+1 <= sweep_length-1 and lag+1 <= lag_count-1,
    // so neither increment can overflow buffer_bits.
    assign k_next   = k_reg + 1'b1;
    assign lag_next = lag_reg + 1'b1;

    // A single adder serves both successors of the current beat:
    //   within a sweep     : lag     + (k + 1)
    //   starting next lag  : (lag+1) + 0
    // The operands are below buffer_length each, so the sum is below
    // 2*buffer_length and one conditional subtract brings it into range.
    // This stays correct for non-power-of-two buffer lengths.
    always_comb begin
        add_a = {1'b0, lag_reg};
        add_b = {1'b0, k_next};
        if (state_reg == NEXT_LAG) begin
            add_a = {1'b0, lag_next};
            add_b = '0;
        end
        sum_ext = add_a + add_b;
        if (sum_ext >= length_ext) begin
            wrap_ext = sum_ext - length_ext;
        end else begin
            wrap_ext = sum_ext;
        end
    end

    // After the wrap the value is below buffer_length, so the top bit is
    // always zero.
    assign index_next      = wrap_ext[buffer_bits-1:0];
    assign unused_wrap_msb = wrap_ext[buffer_bits];

    assign beat_xfer = tvalid_reg && m_axis_index_tready;

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg  <= IDLE;
            lag_reg    <= '0;
            k_reg      <= '0;
            tdata_reg  <= '0;
            tvalid_reg <= 1'b0;
            tlast_reg  <= 1'b0;
            busy_reg   <= 1'b0;
            done_reg   <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    done_reg <= 1'b0;
                    if (start) begin
                        state_reg  <= SWEEP;
                        busy_reg   <= 1'b1;
                        lag_reg    <= '0;
                        k_reg      <= '0;
                        tdata_reg  <= '0;
                        tvalid_reg <= 1'b1;
                        tlast_reg  <= first_is_last;
                    end
                end

                SWEEP: begin
                    // Without a transfer every output simply holds, which
                    // keeps the beat stable under backpressure.
                    if (beat_xfer) begin
                        if (tlast_reg) begin
                            state_reg  <= NEXT_LAG;
                            tvalid_reg <= 1'b0;
                            tlast_reg  <= 1'b0;
                        end else begin
                            k_reg     <= k_next;
                            tdata_reg <= index_next;
                            tlast_reg <= ({1'b0, k_next} == sweep_last);
                        end
                    end
                end

                NEXT_LAG: begin
                    if ({1'b0, lag_reg} < lag_last) begin
                        state_reg  <= SWEEP;
                        lag_reg    <= lag_next;
                        k_reg      <= '0;
                        tdata_reg  <= index_next;
                        tvalid_reg <= 1'b1;
                        tlast_reg  <= first_is_last;
                    end else begin
                        state_reg <= DONE;
                        done_reg  <= 1'b1;
                    end
                end

                DONE: begin
                    // lag keeps its final value until the next run starts.
                    state_reg <= IDLE;
                    done_reg  <= 1'b0;
                    busy_reg  <= 1'b0;
                end

                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign busy                = busy_reg;
    assign done                = done_reg;
    assign m_axis_index_tdata  = tdata_reg;
    assign m_axis_index_tvalid = tvalid_reg;
    assign m_axis_index_tlast  = tlast_reg;
    assign lag                 = lag_reg;

endmodule

// File: tb/tb_reference_index_sequencer.sv
// ---------------------------------------------------------------------------
// tb_reference_index_sequencer
//
// Three sequencer instances with different geometries share one clock:
//   0 : length 8,  sweep 4, lags 3
//   1 : length 8,  sweep 6, lags 4  (last sweep wraps 7 -> 0)
//   2 : length 10, sweep 7, lags 5  (wraps at a non-power-of-two length)
// Inputs are driven and outputs sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_reference_index_sequencer;

    function automatic int len_of(input int i);
        case (i)
            0:       return 8;
            1:       return 8;
            default: return 10;
        endcase
    endfunction

    function automatic int sweep_of(input int i);
        case (i)
            0:       return 4;
            1:       return 6;
            default: return 7;
        endcase
    endfunction

    function automatic int lagc_of(input int i);
        case (i)
            0:       return 3;
            1:       return 4;
            default: return 5;
        endcase
    endfunction

    logic       clk = 1'b0;
    logic [2:0] reset_s;
    logic [2:0] start_s;
    logic [2:0] tready_s;
    wire  [2:0] busy_s;
    wire  [2:0] done_s;
    wire  [2:0] tvalid_s;
    wire  [2:0] tlast_s;
    wire  [3:0] tdata_s [3];
    wire  [3:0] lag_s   [3];

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < 3; gi++) begin : g_dut
        reference_index_sequencer #(
            .buffer_bits   (4),
            .buffer_length (len_of(gi)),
            .sweep_length  (sweep_of(gi)),
            .lag_count     (lagc_of(gi))
        ) dut (
            .clk                 (clk),
            .reset               (reset_s[gi]),
            .start               (start_s[gi]),
            .busy                (busy_s[gi]),
            .done                (done_s[gi]),
            .m_axis_index_tdata  (tdata_s[gi]),
            .m_axis_index_tvalid (tvalid_s[gi]),
            .m_axis_index_tready (tready_s[gi]),
            .m_axis_index_tlast  (tlast_s[gi]),
            .lag                 (lag_s[gi])
        );
    end

    task automatic check(input string tag, input int got, input int exp);
        tests_run++;
        if (got != exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_idle(input int sel, input string tag);
        check($sformatf("%s_busy%0d", tag, sel),   int'(busy_s[sel]),   0);
        check($sformatf("%s_done%0d", tag, sel),   int'(done_s[sel]),   0);
        check($sformatf("%s_tvalid%0d", tag, sel), int'(tvalid_s[sel]), 0);
        check($sformatf("%s_tlast%0d", tag, sel),  int'(tlast_s[sel]),  0);
        check($sformatf("%s_tdata%0d", tag, sel),  int'(tdata_s[sel]),  0);
        check($sformatf("%s_lag%0d", tag, sel),    int'(lag_s[sel]),    0);
    endtask

    // One complete run on instance sel. stall randomises tready; hold keeps
    // start high through the whole run and checks the idle gap before the
    // second run, which is then cut short by reset.
    task automatic run_one(input int sel, input bit stall, input bit hold);
        int len   = len_of(sel);
        int sw    = sweep_of(sel);
        int lc    = lagc_of(sel);
        int beat  = 0;
        bit got_done = 1'b0;
        bit prev_stall = 1'b0;
        bit prev_last_xfer = 1'b0;
        int prev_data = 0;
        int prev_last = 0;
        int prev_lag  = 0;
        int exp_lag;
        int exp_k;

        @(negedge clk);
        start_s[sel]  = 1'b1;
        tready_s[sel] = 1'b1;
        for (int c = 1; c <= 2000 && !got_done; c++) begin
            @(negedge clk);
            if (!hold) start_s[sel] = 1'b0;
            if (c == 1) check($sformatf("latency%0d", sel), int'(tvalid_s[sel]), 1);
            check($sformatf("busy_run%0d", sel), int'(busy_s[sel]), 1);
            if (done_s[sel] === 1'b1) begin
                got_done = 1'b1;
                check($sformatf("beats%0d", sel), beat, lc * sw);
                check($sformatf("done_tvalid%0d", sel), int'(tvalid_s[sel]), 0);
                if (!stall) check($sformatf("run_cycles%0d", sel), c, lc * (sw + 1) + 1);
            end else begin
                if (prev_last_xfer)
                    check($sformatf("gap_tvalid%0d", sel), int'(tvalid_s[sel]), 0);
                if (prev_stall) begin
                    check($sformatf("hold_tvalid%0d", sel), int'(tvalid_s[sel]), 1);
                    check($sformatf("hold_tdata%0d", sel),  int'(tdata_s[sel]),  prev_data);
                    check($sformatf("hold_tlast%0d", sel),  int'(tlast_s[sel]),  prev_last);
                    check($sformatf("hold_lag%0d", sel),    int'(lag_s[sel]),    prev_lag);
                end
                prev_last_xfer = 1'b0;
                prev_stall     = 1'b0;
                if (tvalid_s[sel] === 1'b1) begin
                    tready_s[sel] = stall ? 1'($urandom_range(0, 1)) : 1'b1;
                    if (tready_s[sel]) begin
                        exp_lag = beat / sw;
                        exp_k   = beat % sw;
                        $display("[TB] dut%0d beat %0d lag %0d idx %0d last %0d",
                                 sel, beat, int'(lag_s[sel]), int'(tdata_s[sel]),
                                 int'(tlast_s[sel]));
                        check($sformatf("tdata%0d_b%0d", sel, beat), int'(tdata_s[sel]),
                              (exp_lag + exp_k) % len);
                        check($sformatf("tlast%0d_b%0d", sel, beat), int'(tlast_s[sel]),
                              (exp_k == sw - 1) ? 1 : 0);
                        check($sformatf("lag%0d_b%0d", sel, beat), int'(lag_s[sel]), exp_lag);
                        check($sformatf("range%0d_b%0d", sel, beat),
                              (int'(tdata_s[sel]) < len) ? 1 : 0, 1);
                        prev_last_xfer = tlast_s[sel];
                        beat++;
                    end else begin
                        prev_stall = 1'b1;
                        prev_data  = int'(tdata_s[sel]);
                        prev_last  = int'(tlast_s[sel]);
                        prev_lag   = int'(lag_s[sel]);
                    end
                end
            end
        end
        if (!got_done) check($sformatf("timeout%0d", sel), 0, 1);

        @(negedge clk);
        check($sformatf("post_done%0d", sel), int'(done_s[sel]), 0);
        check($sformatf("post_busy%0d", sel), int'(busy_s[sel]), 0);
        check($sformatf("final_lag%0d", sel), int'(lag_s[sel]), lc - 1);
        if (hold) begin
            @(negedge clk);
            check($sformatf("rerun_busy%0d", sel),   int'(busy_s[sel]),   1);
            check($sformatf("rerun_tvalid%0d", sel), int'(tvalid_s[sel]), 1);
            check($sformatf("rerun_tdata%0d", sel),  int'(tdata_s[sel]),  0);
            start_s[sel] = 1'b0;
            reset_s[sel] = 1'b1;
            @(negedge clk);
            reset_s[sel] = 1'b0;
            check_idle(sel, "rerun_reset");
        end
    endtask

    // Reset while instance 0 presents lag 1, k 2 (index 3).
    task automatic reset_mid_run();
        bit hit = 1'b0;
        @(negedge clk);
        start_s[0]  = 1'b1;
        tready_s[0] = 1'b1;
        for (int c = 0; c < 40 && !hit; c++) begin
            @(negedge clk);
            start_s[0] = 1'b0;
            if (tvalid_s[0] === 1'b1 && lag_s[0] == 4'd1 && tdata_s[0] == 4'd3) begin
                hit = 1'b1;
                $display("[TB] dut0 reset at lag 1 idx 3");
                reset_s[0] = 1'b1;
            end
        end
        check("mid_reset_reached", int'(hit), 1);
        @(negedge clk);
        reset_s[0] = 1'b0;
        check_idle(0, "mid_reset");
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("mid_stay_idle", int'(busy_s[0]), 0);
            check("mid_no_done", int'(done_s[0]), 0);
        end
    endtask

    initial begin
        reset_s  = 3'b111;
        start_s  = 3'b000;
        tready_s = 3'b111;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) check_idle(i, "reset");
        reset_s = 3'b000;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 3; i++) check($sformatf("idle_wait%0d", i), int'(busy_s[i]), 0);

        for (int i = 0; i < 3; i++) run_one(i, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) run_one(i, 1'b1, 1'b0);
        reset_mid_run();
        run_one(0, 1'b0, 1'b0);
        run_one(0, 1'b0, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/reference_index_sequencer.md
REFERENCE_INDEX_SEQUENCER -- requirements
Module: reference_index_sequencer

Interface
REQ-001 SHALL have parameter buffer_bits, default 10, width of the buffer index.
REQ-002 SHALL have parameter buffer_length, default 1024, number of valid buffer entries; legal range 2..2^buffer_bits.
REQ-003 SHALL have parameter sweep_length, default 256, beats per lag sweep; legal range 1..buffer_length.
REQ-004 SHALL have parameter lag_count, default 16, number of lags per run; legal range 1..buffer_length.
REQ-005 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-006 SHALL have port reset, input, 1, synchronous, active-high reset.
REQ-007 SHALL have port start, input, 1, run request, sampled only in IDLE.
REQ-008 SHALL have port busy, output, 1, high in every state except IDLE.
REQ-009 SHALL have port done, output, 1, one-cycle pulse at run completion.
REQ-010 SHALL have port m_axis_index_tdata, output, buffer_bits, buffer index presented to the reference buffer.
REQ-011 SHALL have port m_axis_index_tvalid, output, 1, index valid.
REQ-012 SHALL have port m_axis_index_tready, input, 1, downstream acceptance.
REQ-013 SHALL have port m_axis_index_tlast, output, 1, marks the final beat of each sweep.
REQ-014 SHALL have port lag, output, buffer_bits, lag of the current sweep.

Function
REQ-015 SHALL implement FSM states IDLE, SWEEP, NEXT_LAG, DONE.
REQ-016 In IDLE, start=1 SHALL cause a transition to SWEEP on the next edge, with lag=0 and beat counter k=0.
REQ-017 A beat SHALL transfer only on a cycle where tvalid=1 and tready=1.
REQ-018 In SWEEP, tvalid SHALL be 1; tdata SHALL equal (lag+k) mod buffer_length, computed with one wider add and a conditional subtract of buffer_length, never by power-of-two truncation.
REQ-019 tdata, tlast and lag SHALL be held stable while tvalid=1 and tready=0; tvalid SHALL NOT drop before a transfer.
REQ-020 Each transfer SHALL increment k; tlast SHALL be 1 exactly when k=sweep_length-1.
REQ-021 A transfer with tlast=1 SHALL cause a transition to NEXT_LAG; NEXT_LAG SHALL last exactly one cycle with tvalid=0.
REQ-022 In NEXT_LAG, if lag<lag_count-1, the block SHALL increment lag, clear k and return to SWEEP; otherwise it SHALL go to DONE.
REQ-023 DONE SHALL last one cycle with done=1, then return to IDLE; lag SHALL hold its final value until the next start.
REQ-024 Latency from start to the first valid beat SHALL be 1 cycle; a full run with tready held at 1 SHALL take lag_count*(sweep_length+1)+1 cycles from start to done.
REQ-025 start SHALL be ignored in every state except IDLE, including the DONE cycle.
REQ-026 Index wrap SHALL occur when lag+k equals or exceeds buffer_length, e.g. buffer_length-1 SHALL be followed by 0.
REQ-027 The block SHALL NOT issue indices outside 0..buffer_length-1 under any parameter combination within the legal ranges.

Reset
REQ-028 reset=1 SHALL, at the next edge, force IDLE, busy=0, done=0, tvalid=0, tlast=0, tdata=0, lag=0, k=0.
REQ-029 reset SHALL take priority over start and over any pending handshake; a reset mid-sweep SHALL abandon the run without a done pulse.
REQ-030 After reset deasserts, the block SHALL remain in IDLE until start=1 is sampled.

Verification
REQ-031 Parameters buffer_length=8, sweep_length=4, lag_count=3, tready=1, start pulse -> indices 0,1,2,3 | 1,2,3,4 | 2,3,4,5; tlast on each 4th beat; done 16 cycles after start.
REQ-032 Parameters buffer_length=8, sweep_length=6, lag_count=4 -> lag 3 sweep yields 3,4,5,6,7,0 (wrap).
REQ-033 Random tready backpressure -> tdata/tlast stable while stalled; the beat sequence is identical to the no-stall run.
REQ-034 reset asserted at lag=1, k=2 -> next cycle IDLE, tvalid=0, lag=0; no done pulse; a subsequent start restarts at index 0.
REQ-035 start held high throughout a run and through DONE -> a second run begins only after the block has returned to IDLE; busy=0 for at least one cycle between runs.
REQ-036 Scoreboard: every transferred index is in 0..buffer_length-1, and the transferred beat count equals lag_count*sweep_length.
